// File: rtl/ee271_vm_pkg.sv
// Shared vending-machine definitions: one-hot coin codes, coin values and
// the change-dispenser state encoding.
package ee271_vm_pkg;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b100;

  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int coin_value(input logic [2:0] coin);
    case (coin)
      COIN_NICKEL:  return VAL_NICKEL;
      COIN_DIME:    return VAL_DIME;
      COIN_QUARTER: return VAL_QUARTER;
      default:      return 0;
    endcase
  endfunction

endpackage

// File: rtl/ee271_coin_hopper.sv
// Single coin hopper counter: reload to INIT, decrement without underflow,
// and a nonzero flag used by the coin selector.
module ee271_coin_hopper #(
  parameter int HOP_W = 4,
  parameter int INIT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [HOP_W-1:0] cnt_o,
  output logic             nz_o
);

  logic [HOP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = HOP_W'(INIT);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= HOP_W'(INIT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/ee271_change_dispenser.sv
// Greedy coin-change ejector: pays a requested amount one coin at a time
// from three hoppers and reports any unpaid remainder.
module ee271_change_dispenser
  import ee271_vm_pkg::*;
#(
  parameter int CHG_W       = 6,
  parameter int HOP_W       = 4,
  parameter int HOPPER_INIT = 4,
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [CHG_W-1:0] chg_amt,
  input  logic             refill,
  output logic             chg_ready,
  output logic [2:0]       coin_out,
  output logic             done,
  output logic             short,
  output logic [CHG_W-1:0] short_amt,
  output logic [HOP_W-1:0] q_cnt,
  output logic [HOP_W-1:0] d_cnt,
  output logic [HOP_W-1:0] n_cnt
);

  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CHG_W-1:0] V_Q = CHG_W'(VAL_QUARTER);
  localparam logic [CHG_W-1:0] V_D = CHG_W'(VAL_DIME);
  localparam logic [CHG_W-1:0] V_N = CHG_W'(VAL_NICKEL);

  logic [2:0]       state_q, state_d;
  logic [CHG_W-1:0] rem_q, rem_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       coin_q, coin_d;
  logic             load, dec_q, dec_d, dec_n;
  logic             q_nz, d_nz, n_nz;

  ee271_coin_hopper #(.HOP_W(HOP_W), .INIT(HOPPER_INIT)) u_hop_q (
    .clk(clk), .rst(rst), .load_i(load), .dec_i(dec_q), .cnt_o(q_cnt), .nz_o(q_nz)
  );
  ee271_coin_hopper #(.HOP_W(HOP_W), .INIT(HOPPER_INIT)) u_hop_d (
    .clk(clk), .rst(rst), .load_i(load), .dec_i(dec_d), .cnt_o(d_cnt), .nz_o(d_nz)
  );
  ee271_coin_hopper #(.HOP_W(HOP_W), .INIT(HOPPER_INIT)) u_hop_n (
    .clk(clk), .rst(rst), .load_i(load), .dec_i(dec_n), .cnt_o(n_cnt), .nz_o(n_nz)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    coin_d  = coin_q;
    load    = 1'b0;
    dec_q   = 1'b0;
    dec_d   = 1'b0;
    dec_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (chg_valid) begin
          rem_d   = chg_amt;
          state_d = ST_SELECT;
        end else if (refill) begin
          load = 1'b1;
        end
      end
      ST_SELECT: begin
        timer_d = PULSE_LD;
        state_d = ST_EJECT;
        if (q_nz && (rem_q >= V_Q)) begin
          coin_d = COIN_QUARTER;
          dec_q  = 1'b1;
          rem_d  = rem_q - V_Q;
        end else if (d_nz && (rem_q >= V_D)) begin
          coin_d = COIN_DIME;
          dec_d  = 1'b1;
          rem_d  = rem_q - V_D;
        end else if (n_nz && (rem_q >= V_N)) begin
          coin_d = COIN_NICKEL;
          dec_n  = 1'b1;
          rem_d  = rem_q - V_N;
        end else begin
          timer_d = timer_q;
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (GAP_CYC > 0) begin
          timer_d = GAP_LD;
          state_d = ST_GAP;
        end else begin
          state_d = (rem_q == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_GAP: begin
        // A fully paid amount finishes right after the gap, skipping SELECT.
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = (rem_q == '0) ? ST_DONE : ST_SELECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      timer_q <= '0;
      coin_q  <= COIN_NONE;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
      coin_q  <= coin_d;
    end
  end

  assign chg_ready = (state_q == ST_IDLE);
  assign coin_out  = (state_q == ST_EJECT) ? coin_q : COIN_NONE;
  assign done      = (state_q == ST_DONE);
  assign short     = done && (rem_q != '0);
  assign short_amt = done ? rem_q : '0;

endmodule

// File: tb/tb_ee271_change_dispenser.sv
// Scoreboard bench for ee271_change_dispenser: requests push expected coin
// and done events; a negedge monitor pops and compares them.
module tb_ee271_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       chg_valid;
  logic [5:0] chg_amt;
  logic       refill;
  logic       chg_ready;
  logic [2:0] coin_out;
  logic       done;
  logic       short;
  logic [5:0] short_amt;
  logic [3:0] q_cnt, d_cnt, n_cnt;

  ee271_change_dispenser dut (
    .clk(clk), .rst(rst), .chg_valid(chg_valid), .chg_amt(chg_amt), .refill(refill),
    .chg_ready(chg_ready), .coin_out(coin_out), .done(done), .short(short),
    .short_amt(short_amt), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [2:0] coin;
    bit         shrt;
    int         amt;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [2:0] prev_coin = 3'b000;
  int         last_amt = -1;
  int         last_short = -1;
  int         m_q = 4, m_d = 4, m_n = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_coin(input logic [2:0] c, input int at);
    ev_t e;
    e.is_done = 1'b0; e.coin = c; e.shrt = 1'b0; e.amt = 0; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int rem, input int at);
    ev_t e;
    e.is_done = 1'b1; e.coin = 3'b000; e.shrt = (rem != 0); e.amt = rem; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Greedy payout model: SELECT at c0+1, each coin occupies 1+2+1 cycles.
  task automatic model_req(input int amt, input int c0);
    int rem;
    int t;
    rem = amt;
    t = c0 + 1;
    if (rem == 0) begin
      push_done(0, t + 1);
      return;
    end
    forever begin
      if (m_q > 0 && rem >= 25) begin
        push_coin(3'b100, t + 1); m_q--; rem -= 25;
      end else if (m_d > 0 && rem >= 10) begin
        push_coin(3'b010, t + 1); m_d--; rem -= 10;
      end else if (m_n > 0 && rem >= 5) begin
        push_coin(3'b001, t + 1); m_n--; rem -= 5;
      end else begin
        push_done(rem, t + 1);
        return;
      end
      t += 4;
      if (rem == 0) begin
        push_done(0, t);
        return;
      end
    end
  endtask

  task automatic handle(input bit is_done_ev);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_output done=%0b coin_out=%b required=none (cyc=%0d)",
               done, coin_out, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind_is_done", is_done_ev, e.is_done);
    chk("ev_cycle", cyc, e.cyc);
    if (is_done_ev) begin
      chk("done_short", short, e.shrt);
      chk("done_short_amt", short_amt, e.amt);
      last_amt = short_amt;
      last_short = short;
    end else begin
      chk("coin_code", coin_out, e.coin);
    end
  endtask

  always @(negedge clk) begin
    if (coin_out != 3'b000 && prev_coin == 3'b000) handle(1'b0);
    if (done) handle(1'b1);
    prev_coin <= coin_out;
  end

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_req(input int amt, input bit poke);
    @(negedge clk);
    chk("ready_in_idle", chg_ready, 1);
    model_req(amt, cyc);
    chg_valid = 1'b1;
    chg_amt = 6'(amt);
    @(negedge clk);
    chg_valid = 1'b0;
    chg_amt = '0;
    chk("ready_when_busy", chg_ready, 0);
    if (poke) begin
      @(negedge clk);
      chg_valid = 1'b1;
      chg_amt = 6'd25;
      refill = 1'b1;
      @(negedge clk);
      chg_valid = 1'b0;
      chg_amt = '0;
      refill = 1'b0;
    end
    wait_drain();
  endtask

  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m_q = 4; m_d = 4; m_n = 4;
  endtask

  task automatic chk_counts(input string tag, input int q, input int d, input int n);
    chk({tag, "_q_cnt"}, q_cnt, q);
    chk({tag, "_d_cnt"}, d_cnt, d);
    chk({tag, "_n_cnt"}, n_cnt, n);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    chg_valid = 1'b0;
    chg_amt = '0;
    refill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", chg_ready, 1);
    chk("rst_coin_out", coin_out, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_short_amt", short_amt, 0);
    chk_counts("rst", 4, 4, 4);

    // 40c with full hoppers: quarter, dime, nickel.
    do_req(40, 1'b0);
    chk_counts("pay40", 3, 3, 3);
    chk("pay40_short", last_short, 0);

    // Same request with a request and refill poked while busy.
    do_req(40, 1'b1);
    chk_counts("busy_poke", 2, 2, 2);
    do_refill();
    chk_counts("refill", 4, 4, 4);

    // Zero amount: immediate done.
    do_req(0, 1'b0);
    chk("zero_short_amt", last_amt, 0);
    chk_counts("zero", 4, 4, 4);

    // 7c: one nickel, 2c unpaid.
    do_req(7, 1'b0);
    chk("seven_short_amt", last_amt, 2);
    chk("seven_short", last_short, 1);
    chk_counts("seven", 4, 4, 3);
    do_refill();

    // Drain to q=0, d=1, n=0, then ask for 30c.
    do_req(50, 1'b0);
    do_req(50, 1'b0);
    do_req(20, 1'b0);
    do_req(10, 1'b0);
    for (int i = 0; i < 4; i++) do_req(5, 1'b0);
    chk_counts("drained", 0, 1, 0);
    do_req(30, 1'b0);
    chk("drained_short_amt", last_amt, 20);
    chk("drained_short", last_short, 1);
    chk_counts("drained30", 0, 0, 0);
    do_refill();

    // Reset during the second coin's eject aborts with no done pulse.
    @(negedge clk);
    c0 = cyc;
    push_coin(3'b100, c0 + 2);
    push_coin(3'b010, c0 + 6);
    chg_valid = 1'b1;
    chg_amt = 6'd40;
    @(negedge clk);
    chg_valid = 1'b0;
    chg_amt = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_coin_out", coin_out, 0);
    chk("abort_ready", chg_ready, 1);
    chk("abort_done", done, 0);
    chk_counts("abort", 4, 4, 4);
    repeat (20) @(negedge clk);
    chk("abort_pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
